// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: a bank of 2^AW registers, DW bits each, shared by two
// requesters over a req/ack handshake. Round-robin arbitration with at
// most one access per clock; ack (and read data) follow the grant by one
// cycle.
// Optional feature: define REG_ARB_LOCK_EN to add lock0/lock1 inputs. A
// port granted with its lock input high owns the bank for up to LOCK_MAX
// consecutive grants, or until its lock input drops.
module reg_bank_arbiter #(
    parameter int DW       = 8,
    parameter int AW       = 2,
    parameter int LOCK_MAX = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0,
    input  logic                    we0,
    input  logic [AW-1:0]           addr0,
    input  logic [DW-1:0]           wdata0,
    output logic                    ack0,
    output logic [DW-1:0]           rdata0,
    input  logic                    req1,
    input  logic                    we1,
    input  logic [AW-1:0]           addr1,
    input  logic [DW-1:0]           wdata1,
    output logic                    ack1,
    output logic [DW-1:0]           rdata1,
`ifdef REG_ARB_LOCK_EN
    input  logic                    lock0,
    input  logic                    lock1,
`endif
    output logic [DW*(2**AW)-1:0]   bank_q
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0] regs_q [NREG];
    logic          ack0_q, ack1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;
    logic          ptr_q, ptr_d;       // port that wins a tie

    logic          elig0, elig1;
    logic          gnt_vld, gnt_id;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

`ifdef REG_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic          own_vld_q;
    logic          own_id_q;
    logic [CW-1:0] cnt_q;
    logic          lock_active;
    logic          gnt_lock;
    logic [CW-1:0] cnt_nxt;
`endif

    // Eligibility, lock masking and round-robin selection of one port
    always_comb begin
        elig0 = req0 & ~ack0_q;
        elig1 = req1 & ~ack1_q;
`ifdef REG_ARB_LOCK_EN
        // A live lock shuts out the non-owner entirely.
        lock_active = own_vld_q & (own_id_q ? lock1 : lock0);
        if (lock_active) begin
            if (own_id_q) elig0 = 1'b0;
            else          elig1 = 1'b0;
        end
`endif
        gnt_vld = elig0 | elig1;
        if (elig0 && elig1) gnt_id = ptr_q;
        else                gnt_id = elig1;

        sel_we    = gnt_id ? we1    : we0;
        sel_addr  = gnt_id ? addr1  : addr0;
        sel_wdata = gnt_id ? wdata1 : wdata0;

        ptr_d = ptr_q;
        if (gnt_vld) ptr_d = ~gnt_id;
`ifdef REG_ARB_LOCK_EN
        gnt_lock = gnt_id ? lock1 : lock0;
        cnt_nxt  = (own_vld_q && (own_id_q == gnt_id)) ? cnt_q + 1'b1 : CW'(1);
        // Owner released its lock without a grant this cycle: hand priority over.
        if (!gnt_vld && own_vld_q && !lock_active) ptr_d = ~own_id_q;
`endif
    end

    // Register bank, acks, read data and priority pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ptr_q    <= 1'b0;
        end else begin
            ack0_q <= gnt_vld & ~gnt_id;
            ack1_q <= gnt_vld &  gnt_id;
            ptr_q  <= ptr_d;
            if (gnt_vld) begin
                if (sel_we)      regs_q[sel_addr] <= sel_wdata;
                else if (gnt_id) rdata1_q <= regs_q[sel_addr];
                else             rdata0_q <= regs_q[sel_addr];
            end
        end
    end

`ifdef REG_ARB_LOCK_EN
    // Lock ownership and consecutive-grant counter
    always_ff @(posedge clk) begin
        if (rst) begin
            own_vld_q <= 1'b0;
            own_id_q  <= 1'b0;
            cnt_q     <= '0;
        end else if (gnt_vld && gnt_lock) begin
            if (cnt_nxt >= CW'(LOCK_MAX)) begin
                own_vld_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                own_vld_q <= 1'b1;
                own_id_q  <= gnt_id;
                cnt_q     <= cnt_nxt;
            end
        end else if (own_vld_q && !lock_active) begin
            own_vld_q <= 1'b0;
            cnt_q     <= '0;
        end
    end
`endif

    // Flatten the bank for observation, register 0 in the LSBs
    always_comb begin
        bank_q = '0;
        for (int i = 0; i < NREG; i++) bank_q[i*DW +: DW] = regs_q[i];
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter (DW=8, AW=2). Outputs are
// compared every cycle against a cycle-level behavioural model of the
// arbiter; directed scenarios are followed by randomized traffic.
module tb_reg_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, ack0, req1, we1, ack1;
    logic [1:0]  addr0, addr1;
    logic [7:0]  wdata0, rdata0, wdata1, rdata1;
    logic [31:0] bank_q;
    logic        lock0, lock1;

    // Requester drive state, one entry per port
    logic       r_req [2];
    logic       r_we  [2];
    logic [1:0] r_addr[2];
    logic [7:0] r_wd  [2];

    assign req0 = r_req[0];  assign we0 = r_we[0];
    assign addr0 = r_addr[0]; assign wdata0 = r_wd[0];
    assign req1 = r_req[1];  assign we1 = r_we[1];
    assign addr1 = r_addr[1]; assign wdata1 = r_wd[1];

    // Behavioural model state
    logic [7:0] m_mem[4];
    logic [7:0] m_rd [2];
    logic       m_ack[2];
    int         m_ptr;
    bit         model_on;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

`ifdef REG_ARB_LOCK_EN
    reg_bank_arbiter #(.DW(8), .AW(2), .LOCK_MAX(3)) dut (
`else
    reg_bank_arbiter #(.DW(8), .AW(2), .LOCK_MAX(8)) dut (
`endif
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1),
`ifdef REG_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .bank_q(bank_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Predict the outcome of the coming clock edge from the current inputs.
    task automatic model_step();
        bit e0, e1;
        int w;
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_rd[0] = 8'h00; m_rd[1] = 8'h00;
            m_ack[0] = 1'b0; m_ack[1] = 1'b0;
            m_ptr = 0;
            return;
        end
        e0 = r_req[0] && !m_ack[0];
        e1 = r_req[1] && !m_ack[1];
        m_ack[0] = 1'b0; m_ack[1] = 1'b0;
        if (!e0 && !e1) return;
        if (e0 && e1) w = m_ptr;
        else          w = e1 ? 1 : 0;
        if (r_we[w]) m_mem[r_addr[w]] = r_wd[w];
        else         m_rd[w] = m_mem[r_addr[w]];
        m_ack[w] = 1'b1;
        m_ptr = 1 - w;
    endtask

    task automatic check_all();
        logic [31:0] exp_bank;
        exp_bank = {m_mem[3], m_mem[2], m_mem[1], m_mem[0]};
        check("ack0",   {31'd0, ack0}, {31'd0, m_ack[0]});
        check("ack1",   {31'd0, ack1}, {31'd0, m_ack[1]});
        check("rdata0", {24'd0, rdata0}, {24'd0, m_rd[0]});
        check("rdata1", {24'd0, rdata1}, {24'd0, m_rd[1]});
        check("bank_q", bank_q, exp_bank);
    endtask

    // One clock: model predicts, edge happens, outputs checked at negedge.
    task automatic cycle();
        if (model_on) model_step();
        @(posedge clk);
        @(negedge clk);
        if (model_on) check_all();
    endtask

    task automatic set_port(input int n, input logic rq, input logic w,
                            input logic [1:0] a, input logic [7:0] d);
        r_req[n] = rq; r_we[n] = w; r_addr[n] = a; r_wd[n] = d;
    endtask

    initial begin
        model_on = 1'b1;
        lock0 = 1'b0; lock1 = 1'b0;
        rst = 1'b1;
        set_port(0, 1'b1, 1'b0, 2'd0, 8'h00);
        set_port(1, 1'b1, 1'b0, 2'd0, 8'h00);
        m_ptr = 0;
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        m_rd[0] = 8'h00; m_rd[1] = 8'h00; m_ack[0] = 1'b0; m_ack[1] = 1'b0;
        @(negedge clk);

        // Reset held for 2 cycles with both requests high
        cycle(); cycle();
        check("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        check("rst_bank", bank_q, 32'd0);
        check("rst_rdata", {16'd0, rdata1, rdata0}, 32'd0);
        set_port(0, 1'b0, 1'b0, 2'd0, 8'h00);
        set_port(1, 1'b0, 1'b0, 2'd0, 8'h00);
        rst = 1'b0;
        cycle();

        // Single write then read on port 0
        set_port(0, 1'b1, 1'b1, 2'd2, 8'hBC);
        cycle();
        check("wr_ack0", {31'd0, ack0}, 32'd1);
        set_port(0, 1'b1, 1'b0, 2'd2, 8'h00);
        cycle();
        check("ack_cycle_idle", {31'd0, ack0}, 32'd0);
        cycle();
        check("rd_ack0", {31'd0, ack0}, 32'd1);
        check("rd_data0", {24'd0, rdata0}, 32'h0000_00BC);
        check("bank_r2", {24'd0, bank_q[23:16]}, 32'h0000_00BC);
        set_port(0, 1'b0, 1'b0, 2'd0, 8'h00);
        cycle();

        // Contention right after reset: port 0 first, then port 1
        rst = 1'b1; cycle(); rst = 1'b0;
        set_port(0, 1'b1, 1'b1, 2'd1, 8'h53);
        set_port(1, 1'b1, 1'b1, 2'd1, 8'hA5);
        cycle();
        check("cont_first", {30'd0, ack1, ack0}, 32'd1);
        set_port(0, 1'b0, 1'b0, 2'd0, 8'h00);
        cycle();
        check("cont_second", {30'd0, ack1, ack0}, 32'd2);
        set_port(1, 1'b0, 1'b0, 2'd0, 8'h00);
        check("cont_r1", {24'd0, bank_q[15:8]}, 32'h0000_00A5);
        cycle();

        // Read-before-write ordering on register 3
        set_port(0, 1'b1, 1'b1, 2'd3, 8'h11);
        cycle();
        set_port(0, 1'b1, 1'b1, 2'd3, 8'h22);
        set_port(1, 1'b1, 1'b0, 2'd3, 8'h00);
        cycle();
        check("rbw_ack1", {31'd0, ack1}, 32'd1);
        check("rbw_rdata1", {24'd0, rdata1}, 32'h0000_0011);
        set_port(1, 1'b0, 1'b0, 2'd0, 8'h00);
        cycle();
        check("rbw_ack0", {31'd0, ack0}, 32'd1);
        check("rbw_r3", {24'd0, bank_q[31:24]}, 32'h0000_0022);
        set_port(0, 1'b0, 1'b0, 2'd0, 8'h00);
        cycle();

        // Reset in the same cycle a write is granted
        rst = 1'b1;
        set_port(0, 1'b1, 1'b1, 2'd0, 8'hFF);
        cycle();
        check("rstw_ack", {31'd0, ack0}, 32'd0);
        check("rstw_r0", {24'd0, bank_q[7:0]}, 32'd0);
        rst = 1'b0;
        set_port(0, 1'b0, 1'b0, 2'd0, 8'h00);
        cycle();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (r_req[n] && !m_ack[n]) continue;   // still waiting: hold
                if ($urandom_range(0, 3) != 0)
                    set_port(n, 1'b1, 1'($urandom_range(0, 1)),
                             2'($urandom_range(0, 3)), 8'($urandom));
                else
                    set_port(n, 1'b0, 1'b0, 2'd0, 8'h00);
            end
            rst = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;

`ifdef REG_ARB_LOCK_EN
        // Lock: port 0 keeps lock0 and req0 high; LOCK_MAX = 3
        begin
            logic [1:0] exp_pat[6];
            exp_pat[0] = 2'b01; exp_pat[1] = 2'b00; exp_pat[2] = 2'b01;
            exp_pat[3] = 2'b00; exp_pat[4] = 2'b01; exp_pat[5] = 2'b10;
            model_on = 1'b0;
            rst = 1'b1;
            set_port(0, 1'b0, 1'b0, 2'd0, 8'h00);
            set_port(1, 1'b0, 1'b0, 2'd0, 8'h00);
            cycle();
            rst = 1'b0;
            lock0 = 1'b1;
            set_port(0, 1'b1, 1'b0, 2'd0, 8'h00);
            set_port(1, 1'b1, 1'b0, 2'd1, 8'h00);
            for (int k = 0; k < 6; k++) begin
                cycle();
                check($sformatf("lock_acks_%0d", k), {30'd0, ack1, ack0}, {30'd0, exp_pat[k]});
            end
            lock0 = 1'b0;
            set_port(0, 1'b0, 1'b0, 2'd0, 8'h00);
            set_port(1, 1'b0, 1'b0, 2'd0, 8'h00);
            cycle();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares one bank of 2^AW registers, DW bits each, between two requesters (port 0, port 1).
- Each port issues single read or write accesses over a req/ack handshake.
- Round-robin arbitration; at most one access is performed per clock.
- Sits between two datapath masters and the shared register storage; the storage is internal to this block.

Parameters:
- DW, 8, data width of each register and of wdata/rdata.
- AW, 2, address width; bank holds 2^AW registers.
- LOCK_MAX, 8, maximum consecutive grants one locked port may hold (used only with REG_ARB_LOCK_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  port 0 access request.
- we0  input  1  port 0 write enable (1 = write, 0 = read).
- addr0  input  AW  port 0 register address.
- wdata0  input  DW  port 0 write data.
- ack0  output  1  port 0 access completed (one-cycle pulse).
- rdata0  output  DW  port 0 read data, valid while ack0 = 1.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- lock0, lock1  input  1  hold-bank request (present only with REG_ARB_LOCK_EN).
- bank_q  output  DW*2^AW  flattened current register contents, register 0 in the LSBs.

Behaviour:
- Reset is synchronous and active-high (rst). While rst = 1 at a clock edge:
  - all registers load 0;
  - ack0 = ack1 = 0, rdata0 = rdata1 = 0;
  - priority pointer = port 0;
  - lock owner cleared, lock counter cleared.
- Eligibility: port n is eligible in a cycle when req_n = 1 and ack_n = 0. A port is never granted in the cycle its own ack is high.
- Arbitration is combinational on the eligible set:
  - only one port eligible: that port wins;
  - both eligible: the port named by the priority pointer wins.
- At the clock edge after a grant to port n:
  - if we_n = 1, register[addr_n] loads wdata_n;
  - if we_n = 0, rdata_n loads register[addr_n] (value before any write at that same edge);
  - ack_n = 1 for exactly one cycle;
  - priority pointer moves to the other port.
- Grant-to-ack latency: 1 cycle.
- Requester protocol: hold req/we/addr/wdata stable until ack is seen, then drop req or present the next access. If req is still high during the ack cycle, it is ignored and re-evaluated the following cycle.
- Throughput:
  - one port alone: one access per 2 cycles;
  - both ports active: alternating grants, one access per cycle overall.
- rdata_n holds its last value when ack_n = 0; after a write ack, rdata_n is unchanged.
- Only one access is performed per edge, so no write collision can occur.
- rst asserted while an ack is pending: the ack is cancelled and the granted write is not committed.
- bank_q reflects register contents registered at the clock edge, with no extra delay.

Optional Feature:
- Macro: REG_ARB_LOCK_EN.
- Defined:
  - lock0/lock1 ports exist;
  - a port granted with lock_n = 1 becomes lock owner;
  - while lock_n stays 1, the other port is not granted;
  - the owner may issue up to LOCK_MAX consecutive accesses, each at the normal 1-per-2-cycle rate;
  - the lock counter increments per owner grant;
  - when the counter reaches LOCK_MAX, or lock_n drops, ownership clears, the pointer moves to the other port, and the counter resets to 0;
  - the owner's pending ack still completes normally.
- Undefined: lock ports absent; pure round-robin as described above.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with req0 = req1 = 1 -> ack0 = ack1 = 0, bank_q = 0, rdata0 = rdata1 = 0.
- Single write/read: port 0 writes 8'hBC to addr 2, then reads addr 2 -> ack0 one cycle after each grant; rdata0 = 8'hBC; bank_q[23:16] = 8'hBC.
- Contention after reset: both request in the same cycle, port 0 writes 8'h53 to addr 1, port 1 writes 8'hA5 to addr 1 -> ack0 first, ack1 the next cycle; final register 1 = 8'hA5.
- Read-during-write ordering: register 3 = 8'h11; port 1 reads addr 3 while port 0 writes 8'h22 to addr 3 in the next grant -> rdata1 = 8'h11, register 3 = 8'h22.
- Reset mid-operation: assert rst in the cycle a write of 8'hFF is granted -> no ack; register stays 0.
- REG_ARB_LOCK_EN, LOCK_MAX = 3: port 0 holds lock0 = 1 and req0 = 1 while req1 = 1 -> three ack0 pulses, then ack1; port 1 is granted despite lock0 = 1.
